// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage and the decode stage.
// Contents:
//   OPC_*      7-bit major opcodes that select an immediate format
//   imm_sel_e  immediate-type select for the immediate extender
//   NOP        canonical no-op (addi x0, x0, 0)
package riscv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_sel_e;

endpackage

// File: rtl/imm_type_decoder.sv
// Combinational opcode -> immediate-format decoder. Shared between the
// fetch stage (which registers the result alongside the instruction) and
// the decode stage.
// Ports:
//   opcode_i   instruction bits [6:0]
//   imm_sel_o  immediate format; anything unrecognised falls back to IMM_I
module imm_type_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output imm_sel_e   imm_sel_o
);

  // Straight table lookup on the major opcode. Unknown opcodes produce
  // IMM_I so the extender always sees a legal select.
  always_comb begin
    imm_sel_o = IMM_I;
    case (opcode_i)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: imm_sel_o = IMM_I;
      OPC_STORE:                                  imm_sel_o = IMM_S;
      OPC_BRANCH:                                 imm_sel_o = IMM_B;
      OPC_JAL:                                    imm_sel_o = IMM_J;
      OPC_LUI, OPC_AUIPC:                         imm_sel_o = IMM_U;
      default:                                    imm_sel_o = IMM_I;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with a single outstanding memory request and an
// IF/ID holding register.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req/imem_addr               one-cycle fetch request and its address (= pc)
//   imem_rvalid/imem_rdata           response strobe and instruction word
//   redirect_valid/redirect_pc       branch/jump redirect from downstream
//   id_valid/id_ready                IF/ID handshake
//   id_instr/id_pc/id_pc_plus4       held instruction, its address and address+4
//   id_imm_sel                       immediate format of id_instr
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [2:0]  id_imm_sel
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_e;

  // Fetch addresses are word aligned; the low bits are forced to zero.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        idValid_q, idValid_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic [31:0] idPc_q, idPc_d;
  imm_sel_e    immSel_q, immSel_d;
  imm_sel_e    decodedSel;
  logic        issueReq;
  logic [31:0] redirectTarget;

  assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;

  imm_type_decoder u_imm_dec (
    .opcode_i  (imem_rdata[6:0]),
    .imm_sel_o (decodedSel)
  );

  // State and IF/ID registers. Reset loads a NOP with consistent pc fields
  // so downstream logic never sees X while id_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC_ALIGNED;
      idValid_q <= 1'b0;
      idInstr_q <= NOP;
      idPc_q    <= RESET_PC_ALIGNED;
      immSel_q  <= IMM_I;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idValid_q <= idValid_d;
      idInstr_q <= idInstr_d;
      idPc_q    <= idPc_d;
      immSel_q  <= immSel_d;
    end
  end

  // Next-state logic. A redirect always wins over everything else; in
  // S_WAIT it turns the outstanding request into one that must be drained
  // (S_DROP) unless its response arrives in the same cycle, in which case
  // the response is simply discarded.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idValid_d = idValid_q;
    idInstr_d = idInstr_q;
    idPc_d    = idPc_q;
    immSel_d  = immSel_q;
    issueReq  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d = redirectTarget;
        end else begin
          issueReq = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redirectTarget;
          state_d = imem_rvalid ? S_IDLE : S_DROP;
        end else if (imem_rvalid) begin
          idInstr_d = imem_rdata;
          idPc_d    = pc_q;
          immSel_d  = decodedSel;
          idValid_d = 1'b1;
          pc_d      = pc_q + 32'd4;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          idValid_d = 1'b0;
          pc_d      = redirectTarget;
          state_d   = S_IDLE;
        end else if (id_ready) begin
          issueReq  = 1'b1;
          idValid_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = redirectTarget;
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // S_IDLE would otherwise request while reset is held; gate with rst_n so
  // no request is seen until the unit is actually running.
  assign imem_req    = issueReq & rst_n;
  assign imem_addr   = pc_q;
  assign id_valid    = idValid_q;
  assign id_instr    = idInstr_q;
  assign id_pc       = idPc_q;
  assign id_pc_plus4 = idPc_q + 32'd4;
  assign id_imm_sel  = immSel_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a responding memory model plus a
// transaction-level reference of which address is fetched next and which
// instruction should be presented to decode.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [2:0]  id_imm_sel;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_imm_sel     (id_imm_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory responder
  bit          memBusy = 0;
  bit          memDrop = 0;
  int          memWait = 0;
  int          latMin = 1;
  int          latMax = 1;
  logic [31:0] memAddr = 32'd0;
  bit          rvalidNow = 0;
  bit          lastFromDir = 0;
  logic [31:0] lastWord = 32'd0;
  logic [31:0] directedQ[$];

  // reference model
  logic [31:0] nextAddr = 32'd0;
  bit          visible = 0;
  bit          visDirected = 0;
  logic [31:0] visInstr = 32'd0;
  logic [31:0] visPc = 32'd0;
  logic [31:0] reqLog[$];
  logic [2:0]  expSelQ[$];

  // Memory contents: opcode chosen from a fixed rotation by word address,
  // upper bits derived from the address so each word is distinguishable.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [6:0] op;
    case ((a >> 2) % 10)
      0: op = 7'b0010011;
      1: op = 7'b0000011;
      2: op = 7'b1100111;
      3: op = 7'b1110011;
      4: op = 7'b0100011;
      5: op = 7'b1100011;
      6: op = 7'b1101111;
      7: op = 7'b0110111;
      8: op = 7'b0010111;
      default: op = 7'b0110011;
    endcase
    return {a[26:2] ^ 25'h1A5_A5A5, op};
  endfunction

  function automatic logic [2:0] expSel(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_id_valid"},    {31'd0, id_valid},   32'd0);
    check({tag, "_imem_req"},    {31'd0, imem_req},   32'd0);
    check({tag, "_imem_addr"},   imem_addr,           32'h0000_0000);
    check({tag, "_id_instr"},    id_instr,            32'h0000_0013);
    check({tag, "_id_pc"},       id_pc,               32'h0000_0000);
    check({tag, "_id_pc_plus4"}, id_pc_plus4,         32'h0000_0004);
    check({tag, "_id_imm_sel"},  {29'd0, id_imm_sel}, 32'd0);
  endtask

  task automatic resetModel();
    memBusy = 0; memDrop = 0; memWait = 0; rvalidNow = 0;
    nextAddr = 32'd0; visible = 0; visDirected = 0;
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
  endtask

  // redirMode: 0 none, 1 always, 2 only with a response, 3 only without one
  task automatic applyStimulus(input int redirMode, input logic [31:0] rpc, input bit ready);
    @(posedge clk);
    #1;
    rvalidNow = 0;
    if (memBusy) begin
      memWait--;
      if (memWait <= 0) rvalidNow = 1;
    end
    imem_rvalid = rvalidNow;
    lastFromDir = 0;
    if (rvalidNow) begin
      if (directedQ.size() > 0) begin
        lastWord = directedQ.pop_front();
        lastFromDir = 1;
      end else begin
        lastWord = memWord(memAddr);
      end
      imem_rdata = lastWord;
    end else begin
      imem_rdata = $urandom;
    end
    redirect_valid = (redirMode == 1) || (redirMode == 2 && rvalidNow) ||
                     (redirMode == 3 && !rvalidNow);
    redirect_pc = redirect_valid ? rpc : $urandom;
    id_ready = ready;
  endtask

  task automatic checkOutput();
    bit expReq;
    logic [2:0] s;
    @(negedge clk);
    expReq = !memBusy && !redirect_valid && (!visible || id_ready);
    check("id_valid", {31'd0, id_valid}, {31'd0, visible});
    if (visible) begin
      check("id_instr",    id_instr,            visInstr);
      check("id_pc",       id_pc,               visPc);
      check("id_pc_plus4", id_pc_plus4,         visPc + 32'd4);
      check("id_imm_sel",  {29'd0, id_imm_sel}, {29'd0, expSel(visInstr[6:0])});
      if (visDirected && id_ready && !redirect_valid && expSelQ.size() > 0) begin
        s = expSelQ.pop_front();
        check("directed_imm_sel", {29'd0, id_imm_sel}, {29'd0, s});
      end
    end
    check("imem_req", {31'd0, imem_req}, {31'd0, expReq});
    if (imem_req === 1'b1) check("imem_addr", imem_addr, nextAddr);
  endtask

  task automatic updateModel();
    if (visible && (id_ready || redirect_valid)) visible = 0;
    if (rvalidNow) begin
      memBusy = 0;
      if (!memDrop && !redirect_valid) begin
        visible = 1;
        visDirected = lastFromDir;
        visInstr = lastWord;
        visPc = memAddr;
        nextAddr = memAddr + 32'd4;
      end
    end
    if (redirect_valid) begin
      nextAddr = redirect_pc & 32'hFFFF_FFFC;
      if (memBusy) memDrop = 1;
    end
    if (imem_req === 1'b1) begin
      memBusy = 1;
      memDrop = 0;
      memAddr = imem_addr;
      memWait = $urandom_range(latMax, latMin);
      reqLog.push_back(imem_addr);
    end
  endtask

  task automatic runCycle(input int redirMode, input logic [31:0] rpc, input bit ready);
    applyStimulus(redirMode, rpc, ready);
    checkOutput();
    updateModel();
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    rvalidNow = 0;
    checkOutput();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0000_0000);
    updateModel();
  endtask

  // Directed phases followed by a randomized run, all checked against the
  // reference model every cycle.
  initial begin
    int n;
    int idx;
    bit collided;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");

    // 1-cycle memory, always ready: addresses 0,4,8
    latMin = 1; latMax = 1;
    releaseReset();
    repeat (8) runCycle(0, 32'd0, 1'b1);
    check("seq_count_ok", {31'd0, reqLog.size() >= 3}, 32'd1);
    if (reqLog.size() >= 3) begin
      check("seq_addr0", reqLog[0], 32'h0);
      check("seq_addr1", reqLog[1], 32'h4);
      check("seq_addr2", reqLog[2], 32'h8);
    end

    // 3-cycle memory, decode stalls for 5 cycles
    latMin = 3; latMax = 3;
    n = 0;
    while (!visible && n < 30) begin runCycle(0, 32'd0, 1'b0); n++; end
    check("stall_hold_reached", {31'd0, visible}, 32'd1);
    repeat (5) runCycle(0, 32'd0, 1'b0);
    repeat (6) runCycle(0, 32'd0, 1'b1);

    // redirect during an outstanding request
    n = 0;
    while (!(memBusy && memWait >= 2) && n < 30) begin runCycle(0, 32'd0, 1'b1); n++; end
    check("wait_reached", {31'd0, memBusy}, 32'd1);
    runCycle(3, 32'h0000_0103, 1'b1);
    idx = reqLog.size();
    n = 0;
    while (reqLog.size() == idx && n < 30) begin runCycle(0, 32'd0, 1'b1); n++; end
    check("redir_req_seen", {31'd0, reqLog.size() > idx}, 32'd1);
    if (reqLog.size() > idx) check("redir_addr", reqLog[idx], 32'h0000_0100);

    // redirect colliding with the response
    latMin = 2; latMax = 2;
    collided = 0;
    n = 0;
    while (!collided && n < 30) begin
      runCycle(2, 32'h0000_0200, 1'b1);
      collided = rvalidNow && redirect_valid;
      n++;
    end
    check("collision_reached", {31'd0, collided}, 32'd1);
    idx = reqLog.size();
    runCycle(0, 32'd0, 1'b1);
    check("collision_req", {31'd0, reqLog.size() == idx + 1}, 32'd1);
    if (reqLog.size() > idx) check("collision_addr", reqLog[idx], 32'h0000_0200);

    // immediate-format selection on directed words
    latMin = 1; latMax = 1;
    directedQ = '{32'h00000513, 32'h00a12023, 32'hfe000ee3,
                  32'h0080006f, 32'h000012b7, 32'h00000033};
    expSelQ = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    n = 0;
    while (expSelQ.size() > 0 && n < 60) begin runCycle(0, 32'd0, 1'b1); n++; end
    check("directed_all_seen", expSelQ.size(), 32'd0);

    // pc wrap
    runCycle(1, 32'hFFFF_FFFC, 1'b1);
    idx = reqLog.size();
    n = 0;
    while (reqLog.size() < idx + 2 && n < 40) begin runCycle(0, 32'd0, 1'b1); n++; end
    check("wrap_reqs_seen", {31'd0, reqLog.size() >= idx + 2}, 32'd1);
    if (reqLog.size() >= idx + 2) begin
      check("wrap_addr_top", reqLog[idx], 32'hFFFF_FFFC);
      check("wrap_addr_zero", reqLog[idx + 1], 32'h0000_0000);
    end

    // randomized traffic
    latMin = 1; latMax = 4;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(15);
      runCycle((r == 0) ? 1 : ((r == 1) ? 2 : 0), $urandom, $urandom_range(3) != 0);
    end

    // asynchronous reset while holding an instruction
    n = 0;
    while (!visible && n < 40) begin runCycle(0, 32'd0, 1'b0); n++; end
    check("hold_before_reset", {31'd0, visible}, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    resetModel();
    repeat (2) @(posedge clk);
    releaseReset();
    for (int i = 0; i < 40; i++) runCycle(0, 32'd0, $urandom_range(1) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 imem_req  output  1  one-cycle pulse issuing a fetch of imem_addr.
REQ-005 imem_addr  output  32  fetch address, always equals the internal pc register; bits[1:0] always 0.
REQ-006 imem_rvalid  input  1  response strobe for the single outstanding request; arrives 1 or more cycles after imem_req.
REQ-007 imem_rdata  input  32  instruction word, valid only with imem_rvalid.
REQ-008 redirect_valid  input  1  branch/jump redirect from downstream.
REQ-009 redirect_pc  input  32  redirect target; bits[1:0] ignored (stored as 0).
REQ-010 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-011 id_ready  input  1  decode accepts the instruction when id_valid&&id_ready.
REQ-012 id_instr  output  32  fetched instruction, drives the immediate extender input.
REQ-013 id_pc / id_pc_plus4  output  32 each  address of id_instr and that address + 4 (mod 2^32).
REQ-014 id_imm_sel  output  3  immediate type for the extender: I=000, S=001, B=010, J=011, U=100.

Function
REQ-015 At most one imem request is outstanding at any time; imem_req is never asserted in S_WAIT or S_DROP.
REQ-016 States: S_IDLE, S_WAIT, S_HOLD, S_DROP.
REQ-017 S_IDLE: if redirect_valid, pc<=redirect_pc and stay; else imem_req=1 and go to S_WAIT.
REQ-018 S_WAIT, imem_rvalid without redirect: id_instr<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4, go to S_HOLD.
REQ-019 S_WAIT, redirect_valid without imem_rvalid: pc<=redirect_pc, go to S_DROP.
REQ-020 S_WAIT, redirect_valid and imem_rvalid in the same cycle: response discarded, pc<=redirect_pc, go to S_IDLE.
REQ-021 S_HOLD: id_valid=1 and id_instr/id_pc/id_imm_sel stable until handshake or redirect.
REQ-022 S_HOLD, handshake without redirect: imem_req=1 the same cycle (addr=pc), id_valid<=0, go to S_WAIT; throughput is one instruction per (memory latency + 1) cycles.
REQ-023 S_HOLD, redirect_valid (with or without handshake): the held instruction counts as consumed only if id_ready was high; id_valid<=0, pc<=redirect_pc, no imem_req, go to S_IDLE.
REQ-024 S_DROP: imem_rvalid discards the response and moves to S_IDLE; redirect_valid updates pc (latest redirect wins); both in the same cycle do both.
REQ-025 imem_rvalid in S_IDLE or S_HOLD is a protocol violation and is ignored.
REQ-026 pc increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, likewise id_pc_plus4.
REQ-027 id_imm_sel is registered with id_instr from opcode imem_rdata[6:0]:
- I (000): 0010011, 0000011, 1100111, 1110011.
- S (001): 0100011.
- B (010): 1100011.
- J (011): 1101111.
- U (100): 0110111, 0010111.
- All other opcodes: 000.

Reset
REQ-028 While rst_n=0: state S_IDLE, pc=RESET_PC, id_valid=0, imem_req=0, id_instr=32'h0000_0013 (NOP), id_pc=RESET_PC, id_pc_plus4=RESET_PC+4, id_imm_sel=000.
REQ-029 First imem_req is in the first cycle after rst_n deasserts, with imem_addr=RESET_PC.
REQ-030 Reset asserted mid-request abandons it; a late imem_rvalid after release arrives in S_IDLE/S_WAIT and the memory model must be reset with the unit.

Structure
REQ-031 Shared package riscv_pkg holds opcode localparams, imm_sel enum (IMM_I..IMM_U, 3-bit, same encodings as REQ-014) and NOP constant.
REQ-032 FSM state enum is local to fetch_unit.
REQ-033 Opcode-to-imm_sel mapping is a combinational sub-module imm_type_decoder, reused by the decode stage.

Verification
REQ-034 Reset release, 1-cycle memory, id_ready=1:
- Expected: imem_addr 0,4,8 on successive requests.
- Expected: id_valid every 2nd cycle, id_pc_plus4=id_pc+4.
REQ-035 3-cycle memory, id_ready=0 for 5 cycles after first response:
- Expected: id_instr held stable.
- Expected: no imem_req until id_ready=1.
REQ-036 Redirect to 32'h0000_0103 during S_WAIT:
- Expected: pending response dropped, never visible.
- Expected: next imem_addr 32'h0000_0100.
REQ-037 Redirect and imem_rvalid in the same cycle:
- Expected: id_valid stays 0.
- Expected: next cycle imem_req with the redirect address.
REQ-038 Instructions 32'h00000513, 32'h00a12023, 32'hfe000ee3, 32'h0080006f, 32'h000012b7, 32'h00000033:
- Expected id_imm_sel: 000, 001, 010, 011, 100, 000.
REQ-039 Wrap and reset:
- Start at pc=32'hFFFF_FFFC: expected next fetch 32'h0000_0000.
- rst_n pulsed low in S_HOLD: expected outputs per REQ-028 immediately, without a clock edge.
